// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_LSU    = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick: on a tie the master that did not win last time goes.
module rr_arbiter_2
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = M_LSU;
        end else begin
            grant_idx = M_IFETCH;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto a single-outstanding memory bus.
// Define BUS_TIMEOUT_EN to add a watchdog that aborts a stalled transaction.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MEM_DEPTH      = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned ADDR_WIDTH    = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req_valid,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_data_valid,
    input  logic                  m1_req_valid,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_data_valid,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid,
    output logic                  bus_err
);

    state_e                r_state, w_state;
    logic                  r_last_grant, w_last_grant;
    logic                  r_mem_req_valid, w_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
    logic                  r_mem_we, w_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
    logic [DATA_WIDTH-1:0] r_m0_rdata, w_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata, w_m1_rdata;
    logic                  r_m0_dv, w_m0_dv;
    logic                  r_m1_dv, w_m1_dv;

    logic                  w_grant_valid;
    logic                  w_grant_idx;
    logic                  w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic                  w_tmo_hit;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req         ({m1_req_valid, m0_req_valid}),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt;
    logic             r_bus_err;

    // A response arriving on the limit cycle takes priority over the abort.
    assign w_tmo_hit = (r_state == BUSY) && !mem_data_valid &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_tmo_cnt = r_tmo_cnt;
        if (r_state == IDLE) begin
            w_tmo_cnt = '0;
        end else if (!w_tmo_hit) begin
            w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt;
            r_bus_err <= w_tmo_hit;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign bus_err      = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_state         = r_state;
        w_last_grant    = r_last_grant;
        w_mem_req_valid = r_mem_req_valid;
        w_mem_addr      = r_mem_addr;
        w_mem_we        = r_mem_we;
        w_mem_wdata     = r_mem_wdata;
        w_rsp_valid     = 1'b0;
        w_rsp_data      = mem_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state         = BUSY;
                    w_mem_req_valid = 1'b1;
                    w_last_grant    = w_grant_idx;
                    if (w_grant_idx == M_LSU) begin
                        w_mem_addr  = m1_addr;
                        w_mem_we    = m1_we;
                        w_mem_wdata = m1_wdata;
                    end else begin
                        w_mem_addr  = m0_addr;
                        w_mem_we    = m0_we;
                        w_mem_wdata = m0_wdata;
                    end
                end
            end
            BUSY: begin
                if (mem_data_valid || w_tmo_hit) begin
                    w_state         = IDLE;
                    w_mem_req_valid = 1'b0;
                    w_rsp_valid     = 1'b1;
                    if (!mem_data_valid) begin
                        w_rsp_data = DATA_WIDTH'(BUS_ERR_DATA);
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // r_last_grant doubles as the owner of the in-flight transaction.
    assign w_m0_dv    = w_rsp_valid && (r_last_grant == M_IFETCH);
    assign w_m1_dv    = w_rsp_valid && (r_last_grant == M_LSU);
    assign w_m0_rdata = w_m0_dv ? w_rsp_data : r_m0_rdata;
    assign w_m1_rdata = w_m1_dv ? w_rsp_data : r_m1_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_last_grant    <= M_LSU;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= 1'b0;
            r_mem_wdata     <= '0;
            r_m0_rdata      <= '0;
            r_m1_rdata      <= '0;
            r_m0_dv         <= 1'b0;
            r_m1_dv         <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_last_grant    <= w_last_grant;
            r_mem_req_valid <= w_mem_req_valid;
            r_mem_addr      <= w_mem_addr;
            r_mem_we        <= w_mem_we;
            r_mem_wdata     <= w_mem_wdata;
            r_m0_rdata      <= w_m0_rdata;
            r_m1_rdata      <= w_m1_rdata;
            r_m0_dv         <= w_m0_dv;
            r_m1_dv         <= w_m1_dv;
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_mem_wdata;
    assign m0_rdata      = r_m0_rdata;
    assign m1_rdata      = r_m1_rdata;
    assign m0_data_valid = r_m0_dv;
    assign m1_data_valid = r_m1_dv;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a transaction model.
// Define BUS_TIMEOUT_EN to also exercise the watchdog abort.
module tb_mem_bus_arbiter;
    import bus_pkg::*;

    localparam int unsigned MEM_DEPTH      = 64;
    localparam int unsigned DW             = 32;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned AW             = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    m_req;
    logic [AW-1:0] m_addr [2];
    logic [1:0]    m_we;
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_data_valid, m1_data_valid;
    logic          mem_req_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_data_valid;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .MEM_DEPTH      (MEM_DEPTH),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_req_valid   (m_req[0]),
        .m0_addr        (m_addr[0]),
        .m0_we          (m_we[0]),
        .m0_wdata       (m_wdata[0]),
        .m0_rdata       (m0_rdata),
        .m0_data_valid  (m0_data_valid),
        .m1_req_valid   (m_req[1]),
        .m1_addr        (m_addr[1]),
        .m1_we          (m_we[1]),
        .m1_wdata       (m_wdata[1]),
        .m1_rdata       (m1_rdata),
        .m1_data_valid  (m1_data_valid),
        .mem_req_valid  (mem_req_valid),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .bus_err        (bus_err)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Transaction-level reference: who owns the bus, what it asked for, what each master holds.
    bit            mdl_busy;
    int            mdl_owner;
    int            mdl_last;
    int            mdl_age;
    txn_t          mdl_txn;
    logic [DW-1:0] mdl_rdata [2];
    logic [DW-1:0] ref_mem [MEM_DEPTH];
    bit            granted_now;
    int            grant_log[$];
    int            pulses [2];
    int            err_pulses;

    // Memory slave and master stimulus state.
    logic [DW-1:0] slv_mem [MEM_DEPTH];
    int            slv_cnt;
    int            slv_lat;
    bit            slv_rand, slv_spur, slv_dead;
    bit            withdraw_arm [2];
    bit            withdrawn [2];
    txn_t          q0[$], q1[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input int addr, input bit we, input logic [DW-1:0] wdata);
        txn_t t;
        t.addr  = AW'(addr);
        t.we    = we;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic monitor();
        bit exp_dv [2];
        bit exp_err;
        int w;
        exp_dv[0]   = 1'b0;
        exp_dv[1]   = 1'b0;
        exp_err     = 1'b0;
        granted_now = 1'b0;
        if (mdl_busy) begin
            if (mem_data_valid) begin
                exp_dv[mdl_owner] = 1'b1;
                if (mdl_txn.we) begin
                    ref_mem[mdl_txn.addr] = mdl_txn.wdata;
                    mdl_rdata[mdl_owner]  = mem_rdata;
                end else begin
                    mdl_rdata[mdl_owner] = ref_mem[mdl_txn.addr];
                end
                mdl_busy = 1'b0;
            end else begin
                mdl_age++;
`ifdef BUS_TIMEOUT_EN
                if (mdl_age == TIMEOUT_CYCLES) begin
                    exp_dv[mdl_owner]    = 1'b1;
                    exp_err              = 1'b1;
                    mdl_rdata[mdl_owner] = 32'hDEAD_BEEF;
                    mdl_busy             = 1'b0;
                end
`endif
            end
        end else if (m_req != 2'b00) begin
            if (m_req == 2'b11) w = 1 - mdl_last;
            else w = m_req[1] ? 1 : 0;
            mdl_busy      = 1'b1;
            mdl_owner     = w;
            mdl_last      = w;
            mdl_age       = 0;
            mdl_txn.addr  = m_addr[w];
            mdl_txn.we    = m_we[w];
            mdl_txn.wdata = m_wdata[w];
            granted_now   = 1'b1;
            grant_log.push_back(w);
        end
        check_eq("mem_req_valid", mem_req_valid, mdl_busy);
        if (mdl_busy) begin
            check_eq("mem_addr", mem_addr, mdl_txn.addr);
            check_eq("mem_we", mem_we, mdl_txn.we);
            check_eq("mem_wdata", mem_wdata, mdl_txn.wdata);
        end
        check_eq("m0_data_valid", m0_data_valid, exp_dv[0]);
        check_eq("m1_data_valid", m1_data_valid, exp_dv[1]);
        check_eq("m0_rdata", m0_rdata, mdl_rdata[0]);
        check_eq("m1_rdata", m1_rdata, mdl_rdata[1]);
        check_eq("bus_err", bus_err, exp_err);
        if (m0_data_valid) pulses[0]++;
        if (m1_data_valid) pulses[1]++;
        if (bus_err) err_pulses++;
    endtask

    task automatic slave();
        mem_data_valid = 1'b0;
        if (mem_req_valid && !slv_dead) begin
            if (slv_cnt == 0) slv_cnt = slv_rand ? int'($urandom_range(4, 1)) : slv_lat;
            if (slv_cnt == 1) begin
                if (mem_we) begin
                    slv_mem[mem_addr] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = slv_mem[mem_addr];
                end
                mem_data_valid = 1'b1;
                slv_cnt = 0;
            end else begin
                slv_cnt--;
            end
        end else if (!mem_req_valid && slv_spur && ($urandom_range(3, 0) == 0)) begin
            mem_data_valid = 1'b1;
            mem_rdata = $urandom;
        end
    endtask

    task automatic driver();
        txn_t t;
        bit   dv;
        for (int i = 0; i < 2; i++) begin
            dv = (i == 0) ? m0_data_valid : m1_data_valid;
            if (dv && qsize(i) > 0) begin
                qpop(i);
                withdrawn[i] = 1'b0;
            end
            if (withdraw_arm[i] && granted_now && mdl_owner == i) begin
                m_req[i]        = 1'b0;
                m_addr[i]       = m_addr[i] + 1'b1;
                withdrawn[i]    = 1'b1;
                withdraw_arm[i] = 1'b0;
            end else if (!withdrawn[i]) begin
                if (qsize(i) > 0) begin
                    t          = qhead(i);
                    m_req[i]   = 1'b1;
                    m_addr[i]  = t.addr;
                    m_we[i]    = t.we;
                    m_wdata[i] = t.wdata;
                end else begin
                    m_req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
        slave();
        driver();
    endtask

    task automatic run_drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((qsize(0) > 0 || qsize(1) > 0 || mdl_busy) && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, (qsize(0) == 0 && qsize(1) == 0 && !mdl_busy), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_mem_req_valid"}, mem_req_valid, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_we"}, mem_we, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_m0_dv"}, m0_data_valid, 0);
        check_eq({tag, "_m1_dv"}, m1_data_valid, 0);
        check_eq({tag, "_m0_rdata"}, m0_rdata, 0);
        check_eq({tag, "_m1_rdata"}, m1_rdata, 0);
        check_eq({tag, "_bus_err"}, bus_err, 0);
    endtask

    task automatic model_reset();
        mdl_busy     = 1'b0;
        mdl_last     = 1;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        q0.delete();
        q1.delete();
        m_req        = 2'b00;
        for (int i = 0; i < 2; i++) begin
            withdrawn[i]    = 1'b0;
            withdraw_arm[i] = 1'b0;
        end
        slv_cnt        = 0;
        mem_data_valid = 1'b0;
    endtask

    // Reset is asserted a little after a rising edge, i.e. asynchronously.
    task automatic do_async_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required to finish earlier");
        $fatal(1);
    end

    initial begin
        int n0, n1, k;
        reset     = 1'b0;
        m_addr[0] = '0;
        m_addr[1] = '0;
        m_we      = 2'b00;
        m_wdata[0] = '0;
        m_wdata[1] = '0;
        mem_rdata = '0;
        slv_lat   = 2;
        slv_rand  = 1'b0;
        slv_spur  = 1'b0;
        slv_dead  = 1'b0;
        mdl_age   = 0;
        mdl_owner = 0;
        mdl_txn   = '0;
        err_pulses = 0;
        model_reset();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            slv_mem[i] = 32'hA5A5_0000 | i;
            ref_mem[i] = 32'hA5A5_0000 | i;
        end
        slv_mem[5] = 32'h1234_5678;
        ref_mem[5] = 32'h1234_5678;

        #12;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        // Single master read, latency 2.
        pulses = '{0, 0};
        slv_lat = 2;
        q0.push_back(mk(5, 1'b0, '0));
        run_drain("t1", 40);
        check_eq("t1_m0_pulses", pulses[0], 1);
        check_eq("t1_m1_pulses", pulses[1], 0);
        check_eq("t1_m0_rdata", m0_rdata, 32'h1234_5678);

        // Both masters held for three transactions each, starting from reset.
        do_async_reset("t2_rst");
        pulses = '{0, 0};
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1 + i, 1'b0, '0));
            q1.push_back(mk(10 + i, 1'b0, '0));
        end
        run_drain("t2", 80);
        check_eq("t2_grant_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size(); i++) begin
            check_eq($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
        end
        check_eq("t2_m0_pulses", pulses[0], 3);
        check_eq("t2_m1_pulses", pulses[1], 3);

        // Write from master 1, then read back from master 0.
        slv_lat = 3;
        q1.push_back(mk(9, 1'b1, 32'hCAFE_F00D));
        run_drain("t3w", 40);
        q0.push_back(mk(9, 1'b0, '0));
        run_drain("t3r", 40);
        check_eq("t3_m0_rdata", m0_rdata, 32'hCAFE_F00D);

        // Master 0 drops its request and changes address right after the grant.
        pulses = '{0, 0};
        withdraw_arm[0] = 1'b1;
        q0.push_back(mk(20, 1'b0, '0));
        run_drain("t4", 40);
        check_eq("t4_m0_pulses", pulses[0], 1);
        check_eq("t4_m0_rdata", m0_rdata, 32'hA5A5_0014);

        // Reset while a transaction is in flight, then a stale response.
        slv_lat = 4;
        q0.push_back(mk(7, 1'b0, '0));
        k = 0;
        while (!mdl_busy && k < 10) begin
            tick();
            k++;
        end
        check_eq("t5_reached_busy", mdl_busy, 1);
        do_async_reset("t5_rst");
        mem_data_valid = 1'b1;
        mem_rdata = 32'h5151_5151;
        pulses = '{0, 0};
        for (int i = 0; i < 3; i++) tick();
        check_eq("t5_stale_m0", pulses[0], 0);
        check_eq("t5_stale_m1", pulses[1], 0);
        grant_log.delete();
        slv_lat = 2;
        q0.push_back(mk(1, 1'b0, '0));
        q1.push_back(mk(2, 1'b0, '0));
        run_drain("t5", 40);
        check_eq("t5_tie_winner", grant_log[0], 0);

`ifdef BUS_TIMEOUT_EN
        // Memory never answers: the watchdog must abort.
        slv_dead = 1'b1;
        pulses = '{0, 0};
        err_pulses = 0;
        q0.push_back(mk(3, 1'b0, '0));
        run_drain("t6", 40);
        check_eq("t6_err_pulses", err_pulses, 1);
        check_eq("t6_m0_pulses", pulses[0], 1);
        check_eq("t6_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        slv_dead = 1'b0;
        q0.push_back(mk(5, 1'b0, '0));
        run_drain("t6b", 40);
        check_eq("t6b_m0_rdata", m0_rdata, 32'h1234_5678);
`endif

        // Random traffic with random latency and spurious idle responses.
        slv_rand = 1'b1;
        slv_spur = 1'b1;
        pulses = '{0, 0};
        n0 = int'($urandom_range(20, 10));
        n1 = int'($urandom_range(20, 10));
        for (int i = 0; i < n0; i++) begin
            q0.push_back(mk(int'($urandom_range(7, 0)), ($urandom_range(2, 0) == 0), $urandom));
        end
        for (int i = 0; i < n1; i++) begin
            q1.push_back(mk(int'($urandom_range(7, 0)), ($urandom_range(2, 0) == 0), $urandom));
        end
        run_drain("rand", 4000);
        check_eq("rand_m0_pulses", pulses[0], n0);
        check_eq("rand_m1_pulses", pulses[1], n1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master to one-slave arbiter on the custom memory bus between the core's instruction-fetch port (master 0) and load/store port (master 1), and Mem_top.
- Uses round-robin arbitration, with one outstanding transaction at a time.
- Latches the winning request and drives it onto the memory bus until Mem_top returns data_valid, then routes the response back to the granted master.

Parameters:
- MEM_DEPTH, 64, memory depth in words; ADDR_WIDTH = $clog2(MEM_DEPTH) (localparam).
- DATA_WIDTH, 32, bus data width.
- TIMEOUT_CYCLES, 16, watchdog limit; used only when BUS_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req_valid  input  1  master 0 request.
- m0_addr  input  ADDR_WIDTH  master 0 word address.
- m0_we  input  1  master 0 write enable.
- m0_wdata  input  DATA_WIDTH  master 0 write data.
- m0_rdata  output  DATA_WIDTH  master 0 read data.
- m0_data_valid  output  1  master 0 completion pulse.
- m1_req_valid, m1_addr, m1_we, m1_wdata, m1_rdata, m1_data_valid: same as master 0, for master 1.
- mem_req_valid  output  1  request to Mem_top.
- mem_addr  output  ADDR_WIDTH  address to Mem_top.
- mem_we  output  1  write enable to Mem_top.
- mem_wdata  output  DATA_WIDTH  write data to Mem_top.
- mem_rdata  input  DATA_WIDTH  read data from Mem_top.
- mem_data_valid  input  1  completion pulse from Mem_top.
- bus_err  output  1  timeout abort pulse (constant 0 without BUS_TIMEOUT_EN).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=1 (so master 0 wins the first tie).
  - mem_req_valid=0, mem_addr=0, mem_we=0, mem_wdata=0.
  - m0/m1_data_valid=0, m0/m1_rdata=0, bus_err=0, timeout counter=0.
- Master protocol: master holds req_valid until it sees its own data_valid pulse. Request fields are sampled only on the grant cycle.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If any req_valid is asserted, grant one master and latch its addr/we/wdata into the mem_* registers.
  - Set mem_req_valid=1 and last_grant=winner; go to BUSY. Request is visible on the bus one cycle after the grant edge.
- Winner selection:
  - Only one master requesting: that master.
  - Both requesting: the master that is not last_grant.
- BUSY:
  - mem_req_valid and mem_* fields stay constant, regardless of master inputs.
  - On mem_data_valid=1, clear mem_req_valid and go to IDLE on that edge.
  - On the same edge, register granted master's data_valid=1 and rdata=mem_rdata.
  - Data_valid is a one-cycle pulse; the other master's data_valid stays 0.
  - Rdata holds its value until that master's next completion.
  - The write response also pulses data_valid; rdata is updated with mem_rdata (don't-care for writes).
- Latency:
  - Grant edge → mem_req_valid high.
  - Mem response edge → master data_valid high one cycle later.
  - At least one IDLE cycle between transactions.
- A master deasserting req_valid mid-BUSY does not abort the transaction; the response is still pulsed.
- mem_data_valid while IDLE is ignored: no pulse, no state change.
- Reset mid-BUSY: immediate return to reset values; the in-flight transaction is dropped.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - If the count reaches TIMEOUT_CYCLES-1 without mem_data_valid, the transaction aborts:
    - mem_req_valid=0, state=IDLE;
    - granted master data_valid pulses with rdata=BUS_ERR_DATA;
    - bus_err pulses for one cycle.
  - mem_data_valid in the same cycle as the limit wins; normal completion, no error.
- BUS_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Decomposition:
- Package bus_pkg:
  - state encoding IDLE=1'b0, BUSY=1'b1;
  - BUS_ERR_DATA=32'hDEAD_BEEF;
  - master index constants M_IFETCH=0, M_LSU=1.
- Sub-module rr_arbiter_2: inputs req[1:0], last_grant; outputs grant_valid, grant_idx; combinational.
- Top holds the FSM, latches and response routing.

Test Plan:
- Read, single master:
  - m0 reads addr 5 (mem preloaded 32'h1234_5678), memory latency 2.
  - mem_req_valid with addr 5, we=0 one cycle after the grant; m0_data_valid pulses once with m0_rdata=32'h1234_5678; m1_data_valid stays 0.
- Simultaneous requests after reset, both held 3 transactions each:
  - Grant order m0, m1, m0, m1, m0, m1.
  - Each completion goes only to its owner; IDLE cycle between transactions.
- Write then read:
  - m1 writes 32'hCAFE_F00D to addr 9, then m0 reads addr 9.
  - mem_we=1 and mem_wdata=32'hCAFE_F00D held until the response; the m0 read returns 32'hCAFE_F00D.
- Master withdraws:
  - m0 deasserts req_valid and changes addr the cycle after grant.
  - mem_addr is unchanged, and m0_data_valid still pulses.
- Reset mid-transaction:
  - reset=0 asserted during BUSY, asynchronously mid-cycle.
  - mem_req_valid=0 immediately; a later stale mem_data_valid gives no master pulse.
  - After release, m0 wins a tie.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Memory never responds.
  - After 16 BUSY cycles: bus_err pulse, m0_data_valid pulse with rdata=32'hDEAD_BEEF, state IDLE, next request served normally.
